// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1: 8N1 UART receiver clocked by the system clock, with an internal baud counter.
//
// Ports:
//   hw_clk    in   system clock (12 MHz nominal)
//   rst_n     in   asynchronous active-low reset
//   uartrx    in   serial input, asynchronous to hw_clk, idles high
//   rx_data   out  last good byte, held until the next good frame
//   rx_valid  out  one-cycle pulse when rx_data has just been updated
//   frame_err out  one-cycle pulse when a stop bit is sampled low
//   rx_busy   out  high whenever the receiver is not idle
//
// Parameter CLKS_PER_BIT: hw_clk cycles per bit (>= 8).
//
// Optional feature macro UART_RX_MAJORITY_EN: every sample becomes a 2-of-3 vote of the
// synchronised line around the sample point; decisions (and outputs) land one cycle later.
module uart_rx_8n1 #(
    parameter int unsigned CLKS_PER_BIT = 1250
) (
    input  logic       hw_clk,
    input  logic       rst_n,
    input  logic       uartrx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);

`ifdef UART_RX_MAJORITY_EN
    // Start decision moves one cycle past the centre so the vote can see the +1 sample. Every
    // later bit is counted from that decision, so data/stop decisions stay at CLKS_PER_BIT-1
    // while their vote window is centred on CLKS_PER_BIT-2.
    localparam logic [CntW-1:0] StartCnt = CntW'(CLKS_PER_BIT / 2);
`else
    localparam logic [CntW-1:0] StartCnt = CntW'(CLKS_PER_BIT / 2 - 1);
`endif
    localparam logic [CntW-1:0] BitCnt = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_e;

    logic [1:0]      sync_q;
    logic            rx_s;
    logic            sample;
    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      idx_q;
    logic [7:0]      sh_q;
    logic [7:0]      rx_data_q;
    logic            rx_valid_q;
    logic            frame_err_q;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge hw_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], uartrx};
        end
    end

    assign rx_s = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
    // hist_q[0] is rx_s one cycle ago, hist_q[1] two cycles ago.
    logic [1:0] hist_q;

    always_ff @(posedge hw_clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], rx_s};
        end
    end

    assign sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
    assign sample = rx_s;
`endif

    always_ff @(posedge hw_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            idx_q       <= '0;
            sh_q        <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    if (!rx_s) begin
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (cnt_q == StartCnt) begin
                        cnt_q <= '0;
                        idx_q <= '0;
                        // A high centre means the falling edge was a glitch.
                        state_q <= sample ? StIdle : StData;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StData: begin
                    if (cnt_q == BitCnt) begin
                        cnt_q <= '0;
                        sh_q  <= {sample, sh_q[7:1]};
                        if (idx_q == 3'd7) begin
                            state_q <= StStop;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StStop: begin
                    if (cnt_q == BitCnt) begin
                        cnt_q <= '0;
                        if (sample) begin
                            rx_data_q  <= sh_q;
                            rx_valid_q <= 1'b1;
                            state_q    <= StIdle;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= StBreak;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StBreak: begin
                    // Hold here while the line stays low so a break yields one error only.
                    cnt_q <= '0;
                    if (rx_s) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign rx_busy   = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_8n1.sv
`timescale 1ns/1ps
module tb_uart_rx_8n1;

    localparam int Cpb    = 32;
    localparam int CpbBig = 1250;
`ifdef UART_RX_MAJORITY_EN
    localparam int Maj = 1;
`else
    localparam int Maj = 0;
`endif

    typedef struct {
        longint     cyc;
        bit         fe;
        logic [7:0] data;
    } ev_t;

    logic       clk;
    logic       rst_n_m, rst_n_b;
    logic       rx_m, rx_b;
    logic [7:0] data_m, data_b;
    logic       valid_m, valid_b, ferr_m, ferr_b, busy_m, busy_b;

    longint     cyc;
    int         n_tests;
    int         n_fail;
    ev_t        q_m[$];
    ev_t        q_b[$];
    logic [7:0] last [2];
    int         valid_cnt [2];
    int         ferr_cnt [2];
    longint     last_vcyc [2];
    longint     last_n;

    uart_rx_8n1 #(.CLKS_PER_BIT(Cpb)) u_dut (
        .hw_clk   (clk),
        .rst_n    (rst_n_m),
        .uartrx   (rx_m),
        .rx_data  (data_m),
        .rx_valid (valid_m),
        .frame_err(ferr_m),
        .rx_busy  (busy_m)
    );

    uart_rx_8n1 #(.CLKS_PER_BIT(CpbBig)) u_big (
        .hw_clk   (clk),
        .rst_n    (rst_n_b),
        .uartrx   (rx_b),
        .rx_data  (data_b),
        .rx_valid (valid_b),
        .frame_err(ferr_b),
        .rx_busy  (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) begin
                $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
            end
        end
    endtask

    // Per-cycle comparison of one receiver against the expected-event queue.
    task automatic chk(input int inst, input logic rst, input logic v, input logic fe,
                       input logic b, input logic [7:0] d);
        ev_t e;
        bit  due;
        due = 1'b0;
        if (!rst) last[inst] = 8'h00;
        if (inst == 0) begin
            if (q_m.size() > 0 && q_m[0].cyc == cyc) begin
                e   = q_m.pop_front();
                due = 1'b1;
            end
        end else begin
            if (q_b.size() > 0 && q_b[0].cyc == cyc) begin
                e   = q_b.pop_front();
                due = 1'b1;
            end
        end
        if (due && !e.fe) last[inst] = e.data;
        check((inst == 0) ? "m_valid" : "b_valid", 32'(v), 32'(due && !e.fe));
        check((inst == 0) ? "m_frame_err" : "b_frame_err", 32'(fe), 32'(due && e.fe));
        check((inst == 0) ? "m_rx_data" : "b_rx_data", 32'(d), 32'(last[inst]));
        if (due) check((inst == 0) ? "m_busy_strobe" : "b_busy_strobe", 32'(b), 32'(e.fe));
        if (v === 1'b1) begin
            valid_cnt[inst]++;
            last_vcyc[inst] = cyc;
        end
        if (fe === 1'b1) ferr_cnt[inst]++;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            chk(0, rst_n_m, valid_m, ferr_m, busy_m, data_m);
            chk(1, rst_n_b, valid_b, ferr_b, busy_b, data_b);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_line(input int inst, input logic v);
        if (inst == 0) rx_m = v;
        else rx_b = v;
    endtask

    // Hold the line at v for ncycles cycles; ends in the last driven cycle.
    task automatic drive(input int inst, input logic v, input int ncycles);
        repeat (ncycles) begin
            tick();
            set_line(inst, v);
        end
    endtask

    // Drive the first len cycles of a frame starting next cycle. The expected strobe lands one
    // cycle after the stop-bit centre as seen through the 2-cycle synchroniser.
    task automatic send_frame(input int inst, input logic [7:0] data, input logic stop_bit,
                              input int glitch_bit, input int len, input bit push);
        int         cpb;
        logic [9:0] bits;
        logic [7:0] exp_d;
        logic       v;
        ev_t        e;
        cpb   = (inst == 0) ? Cpb : CpbBig;
        bits  = {stop_bit, data, 1'b0};
        exp_d = data;
        if (glitch_bit >= 0 && Maj == 0) exp_d[glitch_bit] = 1'b0;
        tick();
        last_n = cyc;
        if (push) begin
            e.cyc  = last_n + 3 + cpb / 2 + 9 * cpb + Maj;
            e.fe   = !stop_bit;
            e.data = exp_d;
            if (inst == 0) q_m.push_back(e);
            else q_b.push_back(e);
        end
        for (int k = 0; k < len; k++) begin
            if (k > 0) tick();
            v = bits[k / cpb];
            if (glitch_bit >= 0 && k / cpb == glitch_bit + 1 && k % cpb == cpb / 2) v = 1'b0;
            set_line(inst, v);
        end
    endtask

    initial begin
        int     vc, fc;
        longint n;
        n_tests = 0;
        n_fail  = 0;
        last[0] = 8'h00;
        last[1] = 8'h00;
        valid_cnt[0] = 0;
        valid_cnt[1] = 0;
        ferr_cnt[0]  = 0;
        ferr_cnt[1]  = 0;
        last_vcyc[0] = 0;
        last_vcyc[1] = 0;
        rst_n_m = 1'b0;
        rst_n_b = 1'b0;
        rx_m    = 1'b1;
        rx_b    = 1'b1;
        repeat (4) tick();
        check("reset_data", 32'(data_m), 32'(8'h00));
        check("reset_busy", 32'(busy_m | busy_b), 32'd0);
        rst_n_m = 1'b1;
        rst_n_b = 1'b1;
        drive(0, 1'b1, 4);
        drive(1, 1'b1, 4);
        check("idle_busy", 32'(busy_m | busy_b), 32'd0);

        // 'D' at 1250 clocks per bit.
        vc = valid_cnt[1];
        send_frame(1, 8'h44, 1'b1, -1, 10 * CpbBig, 1);
        drive(1, 1'b1, CpbBig);
        check("d_one_valid", 32'(valid_cnt[1] - vc), 32'd1);
        check("d_latency", 32'(last_vcyc[1] - last_n), 32'(11878 + Maj));
        check("d_data", 32'(data_b), 32'(8'h44));
        check("d_ferr", 32'(ferr_b), 32'd0);
        check("d_busy", 32'(busy_b), 32'd0);

        // False start: 300 low cycles.
        vc = valid_cnt[1];
        fc = ferr_cnt[1];
        drive(1, 1'b0, 300);
        n = cyc - 299;
        check("fs_busy_low", 32'(busy_b), 32'd1);
        drive(1, 1'b1, 331);
        check("fs_cycle", 32'(cyc - n), 32'd630);
        check("fs_idle", 32'(busy_b), 32'd0);
        check("fs_no_strobe", 32'((valid_cnt[1] - vc) + (ferr_cnt[1] - fc)), 32'd0);

        // Back-to-back frames.
        vc = valid_cnt[0];
        fc = ferr_cnt[0];
        send_frame(0, 8'h00, 1'b1, -1, 10 * Cpb, 1);
        send_frame(0, 8'hFF, 1'b1, -1, 10 * Cpb, 1);
        send_frame(0, 8'hA5, 1'b1, -1, 10 * Cpb, 1);
        drive(0, 1'b1, 2 * Cpb);
        check("b2b_count", 32'(valid_cnt[0] - vc), 32'd3);
        check("b2b_ferr", 32'(ferr_cnt[0] - fc), 32'd0);
        check("b2b_last", 32'(data_m), 32'(8'hA5));

        // Bad stop bit followed by a long break.
        vc = valid_cnt[0];
        fc = ferr_cnt[0];
        send_frame(0, 8'h3C, 1'b0, -1, 10 * Cpb, 1);
        drive(0, 1'b0, 20 * Cpb);
        check("brk_busy", 32'(busy_m), 32'd1);
        check("brk_ferr", 32'(ferr_cnt[0] - fc), 32'd1);
        check("brk_valid", 32'(valid_cnt[0] - vc), 32'd0);
        check("brk_data", 32'(data_m), 32'(8'hA5));
        drive(0, 1'b1, 5);
        check("brk_exit", 32'(busy_m), 32'd0);

        // Reset during data bit 4 of 0x55, then 0x81.
        vc = valid_cnt[0];
        drive(0, 1'b1, Cpb);
        send_frame(0, 8'h55, 1'b1, -1, 5 * Cpb + Cpb / 2, 0);
        check("rst_busy_before", 32'(busy_m), 32'd1);
        rst_n_m = 1'b0;
        drive(0, 1'b1, 3);
        check("rst_busy", 32'(busy_m), 32'd0);
        check("rst_data", 32'(data_m), 32'(8'h00));
        rst_n_m = 1'b1;
        drive(0, 1'b1, 12 * Cpb);
        check("rst_no_strobe", 32'(valid_cnt[0] - vc), 32'd0);
        send_frame(0, 8'h81, 1'b1, -1, 10 * Cpb, 1);
        drive(0, 1'b1, 2 * Cpb);
        check("rst_next", 32'(data_m), 32'(8'h81));
        check("rst_count", 32'(valid_cnt[0] - vc), 32'd1);

        // One-cycle low glitch on the bit-2 sample cycle.
        send_frame(0, 8'h44, 1'b1, 2, 10 * Cpb, 1);
        drive(0, 1'b1, 2 * Cpb);
        check("glitch_data", 32'(data_m), (Maj != 0) ? 32'(8'h44) : 32'(8'h40));

        // Random frames, some with bad stop bits.
        for (int i = 0; i < 30; i++) begin
            logic [7:0] d;
            logic       st;
            int         gap;
            d   = 8'($urandom);
            st  = ($urandom_range(0, 5) != 0);
            gap = st ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
            send_frame(0, d, st, -1, 10 * Cpb, 1);
            if (gap > 0) drive(0, 1'b1, gap * Cpb);
        end
        drive(0, 1'b1, 3 * Cpb);
        check("end_busy", 32'(busy_m), 32'd0);
        check("pending_m", 32'(q_m.size()), 32'd0);
        check("pending_b", 32'(q_b.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
